// File: rtl/clk_enable_monitor.sv
// Measures spacing of clk_enable strobes: period report (1-cycle latency), tolerance/timeout flags, counters.
// Define CLK_EN_MONITOR_STATS_EN to add min/max period tracking; otherwise min/max outputs read 0.
module clk_enable_monitor #(
  parameter int EXPECTED_PERIOD = 1250000,
  parameter int TOLERANCE       = 0,
  parameter int CNT_W           = 24
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             clk_en_in,
  input  logic             clear_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid_out,
  output logic             period_err_out,
  output logic             timeout_out,
  output logic [15:0]      pulse_count_out,
  output logic [CNT_W-1:0] min_period_out,
  output logic [CNT_W-1:0] max_period_out
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * EXPECTED_PERIOD - 1);
  localparam logic [CNT_W:0]   EXP_EXT     = (CNT_W+1)'(EXPECTED_PERIOD);
  localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOLERANCE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic [15:0]      pc_q, pc_d;

  logic [CNT_W:0]   meas_ext;
  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] meas_period;
  logic             out_of_tol;

  // One extra bit keeps cnt+1 and the |period - expected| difference overflow-free.
  always_comb begin
    meas_ext    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    diff        = (meas_ext >= EXP_EXT) ? (meas_ext - EXP_EXT) : (EXP_EXT - meas_ext);
    out_of_tol  = (diff > TOL_EXT);
    meas_period = meas_ext[CNT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    to_d     = to_q;
    pc_d     = pc_q;
    if (clear_in) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      err_d    = 1'b0;
      to_d     = 1'b0;
      pc_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clk_en_in) begin
            state_d = MEASURE;
            cnt_d   = '0;
            pc_d    = pc_q + 16'd1;
          end
        end
        MEASURE: begin
          // A strobe on the timeout cycle takes precedence over the timeout.
          if (clk_en_in) begin
            period_d = meas_period;
            valid_d  = 1'b1;
            cnt_d    = '0;
            pc_d     = pc_q + 16'd1;
            if (out_of_tol) err_d = 1'b1;
          end else if (cnt_q == TIMEOUT_CNT) begin
            to_d    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      to_q     <= to_d;
      pc_q     <= pc_d;
    end
  end

  assign period_out       = period_q;
  assign period_valid_out = valid_q;
  assign period_err_out   = err_q;
  assign timeout_out      = to_q;
  assign pulse_count_out  = pc_q;

`ifdef CLK_EN_MONITOR_STATS_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             seen_q, seen_d;
  logic             new_period;

  always_comb begin
    min_d      = min_q;
    max_d      = max_q;
    seen_d     = seen_q;
    new_period = !clear_in && (state_q == MEASURE) && clk_en_in;
    if (clear_in) begin
      min_d  = '1;
      max_d  = '0;
      seen_d = 1'b0;
    end else if (new_period) begin
      seen_d = 1'b1;
      if (meas_period < min_q) min_d = meas_period;
      if (meas_period > max_q) max_d = meas_period;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      min_q  <= '1;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      seen_q <= seen_d;
    end
  end

  // Min sits at all-ones until the first period; hide that sentinel.
  assign min_period_out = seen_q ? min_q : '0;
  assign max_period_out = max_q;
`else
  assign min_period_out = '0;
  assign max_period_out = '0;
`endif

endmodule
